// File: rtl/rf_access_arbiter_pkg.sv
// Shared types and constants for the register-file access arbiter.
package rf_access_arbiter_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWrite    = 3'd1,
    StRead     = 3'd2,
    StReadWait = 3'd3,
    StDone     = 3'd4
  } state_e;

  // Requester ids
  localparam logic MasterM0 = 1'b0;
  localparam logic MasterM1 = 1'b1;

  // Default read-data wait bound, in READ_WAIT cycles
  localparam int unsigned DefaultTimeout = 4;

endpackage

// File: rtl/rf_access_arbiter_rr_arbiter_2.sv
// Two-way round-robin picker. The pointer names the favoured requester and is
// moved to the opposite requester when the owner finishes.
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  // Pointer register; reset favours requester 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // After a served request, favour the requester that was not served
  always_comb begin
    ptr_d = ptr_q;
    if (update_i) begin
      ptr_d = ~served_i;
    end
  end

  // Pick: a lone requester wins; on contention the pointer decides
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = 1'b0;
    unique case (req_i)
      2'b11:   gnt_id_o = ptr_q;
      2'b10:   gnt_id_o = 1'b1;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares a single-port register file between two requesters. One transaction
// is in flight at a time; every output is decoded from registered state.
module rf_access_arbiter
  import rf_access_arbiter_pkg::*;
#(
  parameter int unsigned Data_width    = 8,
  parameter int unsigned Address_width = 4,
  parameter int unsigned Timeout       = DefaultTimeout
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     M0_REQ,
  input  logic                     M0_WR,
  input  logic [Address_width-1:0] M0_ADDR,
  input  logic [Data_width-1:0]    M0_WDATA,
  output logic                     M0_DONE,
  output logic                     M0_ERR,
  output logic [Data_width-1:0]    M0_RDATA,
  input  logic                     M1_REQ,
  input  logic                     M1_WR,
  input  logic [Address_width-1:0] M1_ADDR,
  input  logic [Data_width-1:0]    M1_WDATA,
  output logic                     M1_DONE,
  output logic                     M1_ERR,
  output logic [Data_width-1:0]    M1_RDATA,
  output logic                     WrEN,
  output logic                     RdEN,
  output logic [Address_width-1:0] Address,
  output logic [Data_width-1:0]    WrData,
  input  logic [Data_width-1:0]    Rd_data,
  input  logic                     RdData_valid,
  output logic                     BUSY,
  output logic                     OWNER
);

  localparam int unsigned     CntW    = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic [Address_width-1:0] addr_q, addr_d;
  logic [Data_width-1:0]    wdata_q, wdata_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [Data_width-1:0]    rdata0_q, rdata0_d;
  logic [Data_width-1:0]    rdata1_q, rdata1_d;

  logic                     gnt_valid;
  logic                     gnt_id;
  logic                     sel_wr;
  logic [Address_width-1:0] sel_addr;
  logic [Data_width-1:0]    sel_wdata;

  rr_arbiter_2 u_rr_arbiter_2 (
    .clk_i       (CLK),
    .rst_i       (RST),
    .req_i       ({M1_REQ, M0_REQ}),
    .update_i    (state_q == StDone),
    .served_i    (owner_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Request fields of the master the arbiter would grant
  always_comb begin
    sel_wr    = (gnt_id == MasterM1) ? M1_WR    : M0_WR;
    sel_addr  = (gnt_id == MasterM1) ? M1_ADDR  : M0_ADDR;
    sel_wdata = (gnt_id == MasterM1) ? M1_WDATA : M0_WDATA;
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      owner_q  <= MasterM0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next state; unknown encodings fall back to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (gnt_valid) state_d = sel_wr ? StWrite : StRead;
      StWrite:    state_d = StDone;
      StRead:     state_d = StReadWait;
      StReadWait: if (RdData_valid || (cnt_q == CntLast)) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next values: latch grant, count the wait, capture read result
  always_comb begin
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_id;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = 1'b0;
        end
      end
      StRead: cnt_d = '0;
      StReadWait: begin
        // Valid data on the expiry cycle still counts as success
        if (RdData_valid) begin
          err_d = 1'b0;
          if (owner_q == MasterM1) begin
            rdata1_d = Rd_data;
          end else begin
            rdata0_d = Rd_data;
          end
        end else if (cnt_q == CntLast) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    WrEN     = (state_q == StWrite);
    RdEN     = (state_q == StRead);
    BUSY     = (state_q != StIdle);
    OWNER    = owner_q;
    Address  = addr_q;
    WrData   = wdata_q;
    M0_DONE  = (state_q == StDone) && (owner_q == MasterM0);
    M1_DONE  = (state_q == StDone) && (owner_q == MasterM1);
    M0_ERR   = M0_DONE && err_q;
    M1_ERR   = M1_DONE && err_q;
    M0_RDATA = rdata0_q;
    M1_RDATA = rdata1_q;
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with hand-computed expectations.
module tb_rf_access_arbiter;

  localparam int unsigned Dw = 8;
  localparam int unsigned Aw = 4;
  localparam int unsigned To = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          M0_REQ, M0_WR, M1_REQ, M1_WR;
  logic [Aw-1:0] M0_ADDR, M1_ADDR, Address;
  logic [Dw-1:0] M0_WDATA, M1_WDATA, M0_RDATA, M1_RDATA, WrData, Rd_data;
  logic          M0_DONE, M0_ERR, M1_DONE, M1_ERR;
  logic          WrEN, RdEN, RdData_valid, BUSY, OWNER;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 CLK = ~CLK;

  rf_access_arbiter #(
    .Data_width    (Dw),
    .Address_width (Aw),
    .Timeout       (To)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .M0_REQ       (M0_REQ),
    .M0_WR        (M0_WR),
    .M0_ADDR      (M0_ADDR),
    .M0_WDATA     (M0_WDATA),
    .M0_DONE      (M0_DONE),
    .M0_ERR       (M0_ERR),
    .M0_RDATA     (M0_RDATA),
    .M1_REQ       (M1_REQ),
    .M1_WR        (M1_WR),
    .M1_ADDR      (M1_ADDR),
    .M1_WDATA     (M1_WDATA),
    .M1_DONE      (M1_DONE),
    .M1_ERR       (M1_ERR),
    .M1_RDATA     (M1_RDATA),
    .WrEN         (WrEN),
    .RdEN         (RdEN),
    .Address      (Address),
    .WrData       (WrData),
    .Rd_data      (Rd_data),
    .RdData_valid (RdData_valid),
    .BUSY         (BUSY),
    .OWNER        (OWNER)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wren"},   WrEN,     0);
    check_eq({tag, "_rden"},   RdEN,     0);
    check_eq({tag, "_busy"},   BUSY,     0);
    check_eq({tag, "_owner"},  OWNER,    0);
    check_eq({tag, "_addr"},   Address,  0);
    check_eq({tag, "_wdata"},  WrData,   0);
    check_eq({tag, "_m0done"}, M0_DONE,  0);
    check_eq({tag, "_m0err"},  M0_ERR,   0);
    check_eq({tag, "_m0rd"},   M0_RDATA, 0);
    check_eq({tag, "_m1done"}, M1_DONE,  0);
    check_eq({tag, "_m1err"},  M1_ERR,   0);
    check_eq({tag, "_m1rd"},   M1_RDATA, 0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    logic exp_own [4];
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};

    RST = 1'b1;
    M0_REQ = 0; M0_WR = 0; M0_ADDR = '0; M0_WDATA = '0;
    M1_REQ = 0; M1_WR = 0; M1_ADDR = '0; M1_WDATA = '0;
    Rd_data = '0; RdData_valid = 0;
    step();
    step();
    check_all_zero("rst");
    RST = 1'b0;

    // M0 write 0xA5 to 0x3
    M0_REQ = 1; M0_WR = 1; M0_ADDR = 4'h3; M0_WDATA = 8'hA5;
    step();
    check_eq("w0_wren", WrEN, 1);
    check_eq("w0_rden", RdEN, 0);
    check_eq("w0_addr", Address, 4'h3);
    check_eq("w0_wdata", WrData, 8'hA5);
    check_eq("w0_owner", OWNER, 0);
    check_eq("w0_busy", BUSY, 1);
    step();
    check_eq("w0_wren_off", WrEN, 0);
    check_eq("w0_done", M0_DONE, 1);
    check_eq("w0_err", M0_ERR, 0);
    check_eq("w0_m1done", M1_DONE, 0);
    check_eq("w0_m1err", M1_ERR, 0);
    check_eq("w0_m1rd", M1_RDATA, 0);
    M0_REQ = 0;
    step();
    check_eq("w0_idle", BUSY, 0);
    check_eq("w0_done_off", M0_DONE, 0);

    // M1 read of 0x2, valid two cycles after RdEN
    M1_REQ = 1; M1_WR = 0; M1_ADDR = 4'h2;
    step();
    check_eq("r1_rden", RdEN, 1);
    check_eq("r1_addr", Address, 4'h2);
    check_eq("r1_owner", OWNER, 1);
    step();
    check_eq("r1_rden_off", RdEN, 0);
    step();
    check_eq("r1_wait", M1_DONE, 0);
    RdData_valid = 1; Rd_data = 8'h5C;
    step();
    RdData_valid = 0; Rd_data = '0;
    check_eq("r1_done", M1_DONE, 1);
    check_eq("r1_err", M1_ERR, 0);
    check_eq("r1_rdata", M1_RDATA, 8'h5C);
    check_eq("r1_m0done", M0_DONE, 0);
    check_eq("r1_m0rd", M0_RDATA, 0);
    M1_REQ = 0;
    step();
    check_eq("r1_idle", BUSY, 0);

    // Both masters write continuously out of reset: M0, M1, M0, M1
    pulse_reset();
    check_all_zero("rst2");
    M0_REQ = 1; M0_WR = 1; M0_ADDR = 4'h1; M0_WDATA = 8'h11;
    M1_REQ = 1; M1_WR = 1; M1_ADDR = 4'h2; M1_WDATA = 8'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("rr%0d_wren", i), WrEN, 1);
      check_eq($sformatf("rr%0d_owner", i), OWNER, exp_own[i]);
      check_eq($sformatf("rr%0d_addr", i), Address, exp_own[i] ? 4'h2 : 4'h1);
      step();
      check_eq($sformatf("rr%0d_wren_off", i), WrEN, 0);
      check_eq($sformatf("rr%0d_m0done", i), M0_DONE, !exp_own[i]);
      check_eq($sformatf("rr%0d_m1done", i), M1_DONE, exp_own[i]);
      step();
      check_eq($sformatf("rr%0d_idle", i), BUSY, 0);
      check_eq($sformatf("rr%0d_wren_idle", i), WrEN, 0);
    end
    M0_REQ = 0; M1_REQ = 0;

    // M0 read that times out; stray Rd_data must not be captured
    M0_REQ = 1; M0_WR = 0; M0_ADDR = 4'h5; Rd_data = 8'hEE;
    step();
    check_eq("to_rden", RdEN, 1);
    check_eq("to_owner", OWNER, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("to_wait%0d_done", i), M0_DONE, 0);
      check_eq($sformatf("to_wait%0d_busy", i), BUSY, 1);
      check_eq($sformatf("to_wait%0d_rden", i), RdEN, 0);
    end
    step();
    check_eq("to_done", M0_DONE, 1);
    check_eq("to_err", M0_ERR, 1);
    check_eq("to_rdata", M0_RDATA, 0);
    check_eq("to_m1err", M1_ERR, 0);
    M0_REQ = 0;
    step();
    check_eq("to_idle", BUSY, 0);
    RdData_valid = 1; Rd_data = 8'h77;
    step();
    step();
    RdData_valid = 0; Rd_data = '0;
    check_eq("late_m0rd", M0_RDATA, 0);
    check_eq("late_m1rd", M1_RDATA, 0);
    check_eq("late_m0done", M0_DONE, 0);
    check_eq("late_busy", BUSY, 0);

    // Reset during M1 READ_WAIT; M0 then wins a tie
    M1_REQ = 1; M1_WR = 0; M1_ADDR = 4'h6;
    step();
    check_eq("ab_rden", RdEN, 1);
    check_eq("ab_owner", OWNER, 1);
    step();
    step();
    check_eq("ab_wait", BUSY, 1);
    RST = 1'b1; M1_REQ = 0;
    step();
    RST = 1'b0;
    check_all_zero("ab_rst");
    M0_REQ = 1; M0_WR = 1; M0_ADDR = 4'h7; M0_WDATA = 8'h70;
    M1_REQ = 1; M1_WR = 1; M1_ADDR = 4'h8; M1_WDATA = 8'h80;
    step();
    check_eq("ab_first_owner", OWNER, 0);
    check_eq("ab_first_wren", WrEN, 1);
    check_eq("ab_no_m1done", M1_DONE, 0);
    step();
    check_eq("ab_first_done", M0_DONE, 1);
    M0_REQ = 0;
    step();
    step();
    check_eq("ab_second_owner", OWNER, 1);
    check_eq("ab_second_wdata", WrData, 8'h80);
    step();
    check_eq("ab_second_done", M1_DONE, 1);
    M1_REQ = 0;
    step();

    // M0 back-to-back writes; M1 requests once and slots in between
    M0_REQ = 1; M0_WR = 1; M0_ADDR = 4'hA; M0_WDATA = 8'h01;
    step();
    check_eq("bb_w1_owner", OWNER, 0);
    check_eq("bb_w1_wdata", WrData, 8'h01);
    M1_REQ = 1; M1_WR = 1; M1_ADDR = 4'hB; M1_WDATA = 8'h33;
    step();
    check_eq("bb_w1_done", M0_DONE, 1);
    M0_WDATA = 8'h02;
    step();
    step();
    check_eq("bb_m1_owner", OWNER, 1);
    check_eq("bb_m1_addr", Address, 4'hB);
    check_eq("bb_m1_wren", WrEN, 1);
    step();
    check_eq("bb_m1_done", M1_DONE, 1);
    check_eq("bb_m1_m0done", M0_DONE, 0);
    M1_REQ = 0;
    step();
    step();
    check_eq("bb_w2_owner", OWNER, 0);
    check_eq("bb_w2_wdata", WrData, 8'h02);
    check_eq("bb_w2_addr", Address, 4'hA);
    step();
    check_eq("bb_w2_done", M0_DONE, 1);
    M0_REQ = 0;
    step();
    check_eq("bb_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares the single-port register file between two requesters: M0 (system controller command path) and M1 (secondary config/debug host).
- Sequences each access as a one-cycle WrEN or RdEN strobe. For reads, it waits for RdData_valid, with a bounded timeout.
- Returns completion, read data and error flags to the owning requester.
- Arbitration is round-robin; only one transaction is in flight at a time.

Parameters:
- Data_width, 8, register file data width
- Address_width, 4, register file address width
- Timeout, 4, cycles READ_WAIT waits for RdData_valid before aborting (min 2)

Ports:
- CLK  in  1  system clock; single clock domain
- RST  in  1  synchronous, active-high reset
- M0_REQ, M1_REQ  in  1  transaction request; held stable until that master's DONE
- M0_WR, M1_WR  in  1  1 = write, 0 = read
- M0_ADDR, M1_ADDR  in  Address_width  target register
- M0_WDATA, M1_WDATA  in  Data_width  write data
- M0_DONE, M1_DONE  out  1  one-cycle completion pulse
- M0_ERR, M1_ERR  out  1  high with DONE when a read timed out
- M0_RDATA, M1_RDATA  out  Data_width  read result; holds until the next read completion for that master
- WrEN  out  1  register file write strobe
- RdEN  out  1  register file read strobe
- Address  out  Address_width  register file address
- WrData  out  Data_width  register file write data
- Rd_data  in  Data_width  register file read data
- RdData_valid  in  1  register file read data valid
- BUSY  out  1  high in every state except IDLE
- OWNER  out  1  id of the granted master; valid while BUSY

Behaviour:
- Reset (RST high at a CLK edge):
  - State becomes IDLE.
  - All outputs go to 0, including RDATA, Address and WrData.
  - Round-robin pointer favours M0; timeout counter clears.
  - Reset mid-transaction abandons it: no DONE, no further strobe.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - Samples REQ at each edge.
  - If exactly one REQ is high, that master is granted.
  - If both are high, the master favoured by the pointer is granted.
  - On grant, latch OWNER, WR, ADDR and WDATA into Address/WrData. Go to WRITE if WR = 1, else READ.
- WRITE: WrEN = 1 for exactly one cycle; next state DONE.
- READ: RdEN = 1 for exactly one cycle; clear counter; next state READ_WAIT.
- READ_WAIT:
  - RdData_valid = 1: latch Rd_data into the owner's RDATA and go to DONE with ERR = 0.
  - Otherwise increment the counter. When the counter reaches Timeout-1, go to DONE with ERR = 1; RDATA is unchanged.
  - RdData_valid in the same cycle as the timeout expiry counts as success.
- DONE:
  - Owner's DONE = 1 for one cycle, ERR as determined above.
  - Pointer moves to favour the other master.
  - Next state IDLE.
- Requester rule: the master drops REQ in the cycle after its DONE unless it is issuing a new transaction. A still-high REQ is a new request.
- Fairness: if both masters request continuously, grants alternate M0, M1, M0, ...
- Latency from REQ sampled in IDLE:
  - Write: WrEN at +1, DONE at +2.
  - Read: RdEN at +1, READ_WAIT from +2, DONE one cycle after RdData_valid.
- RdData_valid outside READ_WAIT is ignored.
- REQ changes while a master is not granted are legal and have no effect until IDLE.
- The non-owner's DONE, ERR and RDATA are unaffected by the other master's transaction.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package holds:
  - State encodings: IDLE, WRITE, READ, READ_WAIT, DONE.
  - Master id constants: M0 = 0, M1 = 1.
  - Default Timeout.
- Sub-module rr_arbiter_2: 2-way round-robin pick with a pointer-update input, reused for future shared resources.

Test Plan:
- M0 write, addr 0x3, data 0xA5: WrEN with Address 3 / WrData 0xA5 one cycle after the sampling edge; M0_DONE the next cycle; M1 outputs stay 0.
- M1 read, addr 0x2, RdData_valid two cycles after RdEN with Rd_data 0x5C: M1_RDATA = 0x5C, M1_DONE = 1, M1_ERR = 0.
- M0 and M1 request writes together out of reset, held continuously: order M0, M1, M0, M1; exactly one WrEN per transaction.
- M0 read with RdData_valid never asserted, Timeout = 4: M0_DONE with M0_ERR = 1 after 4 READ_WAIT cycles; M0_RDATA unchanged; a later RdData_valid is ignored.
- RST raised during READ_WAIT of an M1 read: next edge gives IDLE with all outputs 0 and no M1_DONE; an M0 request after release is granted first.
- M0 issues back-to-back writes while M1 requests once: M1 is served between M0's first and second writes.
